// File: rtl/wav_stream_pkg.sv
// rtl/wav_stream_pkg.sv - shared stream constants and pointer-width helper
package wav_stream_pkg;

  localparam int WAV_STREAM_DW = 8;

  // Pointer carries one extra wrap bit above the memory address bits.
  function automatic int wav_ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/wav_stream_fifo_mem.sv
// rtl/wav_stream_fifo_mem.sv - DEPTHxDW register array, sync write, comb read
module wav_stream_fifo_mem #(
  parameter int DW    = 8,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/wav_stream_fifo.sv
// rtl/wav_stream_fifo.sv - first-word fall-through ready/valid FIFO with flush
module wav_stream_fifo
  import wav_stream_pkg::*;
#(
  parameter int DW    = WAV_STREAM_DW,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ctl_clr,
  input  logic                       sti_tvalid,
  output logic                       sti_tready,
  input  logic [DW-1:0]              sti_tdata,
  output logic                       sto_tvalid,
  input  logic                       sto_tready,
  output logic [DW-1:0]              sto_tdata,
  output logic [$clog2(DEPTH):0]     sts_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = wav_ptr_width(DEPTH);

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("wav_stream_fifo: DEPTH must be a power of two and at least 2");
  end

  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic          w_empty;
  logic          w_full;
  logic          w_sti_trn;
  logic          w_sto_trn;
  logic          w_we;

  assign w_empty   = (r_wr_ptr == r_rd_ptr);
  assign w_full    = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) &&
                     (r_wr_ptr[AW] != r_rd_ptr[AW]);
  assign w_sti_trn = sti_tvalid & ~w_full;
  assign w_sto_trn = ~w_empty & sto_tready;
  // A write coinciding with a flush is dropped, so keep it out of memory too.
  assign w_we      = w_sti_trn & ~ctl_clr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (ctl_clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_sti_trn) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_sto_trn) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
    end
  end

  wav_stream_fifo_mem #(
    .DW    (DW),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (r_wr_ptr[AW-1:0]),
    .i_wdata (sti_tdata),
    .i_raddr (r_rd_ptr[AW-1:0]),
    .o_rdata (sto_tdata)
  );

  assign sti_tready = ~w_full;
  assign sto_tvalid = ~w_empty;
  assign sts_cnt    = r_wr_ptr - r_rd_ptr;

endmodule

// File: tb/tb_wav_stream_fifo.sv
// tb/tb_wav_stream_fifo.sv - scoreboard bench for wav_stream_fifo (DW=8, DEPTH=4)
module tb_wav_stream_fifo;

  logic       clk;
  logic       rst;
  logic       ctl_clr;
  logic       sti_tvalid;
  logic       sti_tready;
  logic [7:0] sti_tdata;
  logic       sto_tvalid;
  logic       sto_tready;
  logic [7:0] sto_tdata;
  logic [2:0] sts_cnt;

  int checks   = 0;
  int failures = 0;
  logic [7:0] exp_q[$];

  wav_stream_fifo #(.DW(8), .DEPTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .ctl_clr    (ctl_clr),
    .sti_tvalid (sti_tvalid),
    .sti_tready (sti_tready),
    .sti_tdata  (sti_tdata),
    .sto_tvalid (sto_tvalid),
    .sto_tready (sto_tready),
    .sto_tdata  (sto_tdata),
    .sts_cnt    (sts_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every output transfer must match the oldest expected beat.
  always @(negedge clk) begin
    if (rst && sto_tvalid && sto_tready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL out_unexpected actual=%0h required=none t=%0t", sto_tdata, $time);
      end else begin
        chk("out_data", int'(sto_tdata), int'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    rst        = 1'b0;
    ctl_clr    = 1'b0;
    sti_tvalid = 1'b1;
    sti_tdata  = 8'hAA;
    sto_tready = 1'b0;

    // Reset with valid input held high
    repeat (2) @(posedge clk);
    #1;
    chk("rst_tready", int'(sti_tready), 1);
    chk("rst_tvalid", int'(sto_tvalid), 0);
    chk("rst_cnt", int'(sts_cnt), 0);
    sti_tvalid = 1'b0;
    rst = 1'b1;
    step();
    chk("rst_nowrite_cnt", int'(sts_cnt), 0);

    // Fill to full with the drain stalled
    for (int i = 0; i < 4; i++) begin
      sti_tvalid = 1'b1;
      sti_tdata  = 8'(i);
      exp_q.push_back(8'(i));
      step();
      chk("fill_cnt", int'(sts_cnt), i + 1);
    end
    chk("full_tready", int'(sti_tready), 0);
    sti_tdata = 8'h04;
    step();
    chk("held_cnt", int'(sts_cnt), 4);
    chk("held_tready", int'(sti_tready), 0);
    chk("full_tvalid", int'(sto_tvalid), 1);

    // Full with concurrent read: no write on this edge
    sto_tready = 1'b1;
    step();
    chk("fullrd_cnt", int'(sts_cnt), 3);
    chk("fullrd_tready", int'(sti_tready), 1);
    exp_q.push_back(8'h04);
    step();
    chk("rdwr_cnt", int'(sts_cnt), 3);

    // Top back up to full, then drain in order
    sto_tready = 1'b0;
    sti_tdata  = 8'h05;
    exp_q.push_back(8'h05);
    step();
    chk("refull_cnt", int'(sts_cnt), 4);
    sti_tvalid = 1'b0;
    sto_tready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("drain_tvalid", int'(sto_tvalid), 1);
      step();
      chk("drain_cnt", int'(sts_cnt), 3 - i);
    end
    chk("drained_tvalid", int'(sto_tvalid), 0);

    // Empty: no bypass from input to output
    sti_tvalid = 1'b1;
    sti_tdata  = 8'h00;
    #1;
    chk("nobypass_tvalid", int'(sto_tvalid), 0);

    // Streaming with wrap: occupancy stays at 1, no gaps
    for (int i = 0; i < 20; i++) begin
      sti_tdata = 8'(i);
      exp_q.push_back(8'(i));
      step();
      chk("stream_cnt", int'(sts_cnt), 1);
      chk("stream_tvalid", int'(sto_tvalid), 1);
    end
    sti_tvalid = 1'b0;
    step();
    chk("stream_end_cnt", int'(sts_cnt), 0);

    // Flush with three beats stored and a concurrent write
    sto_tready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sti_tvalid = 1'b1;
      sti_tdata  = 8'hA0 + 8'(i);
      exp_q.push_back(8'hA0 + 8'(i));
      step();
    end
    chk("preflush_cnt", int'(sts_cnt), 3);
    ctl_clr   = 1'b1;
    sti_tdata = 8'hEE;
    step();
    ctl_clr    = 1'b0;
    sti_tvalid = 1'b0;
    exp_q.delete();
    chk("flush_cnt", int'(sts_cnt), 0);
    chk("flush_tvalid", int'(sto_tvalid), 0);
    chk("flush_tready", int'(sti_tready), 1);

    // Refill two beats, then asynchronous reset mid-cycle
    for (int i = 0; i < 2; i++) begin
      sti_tvalid = 1'b1;
      sti_tdata  = 8'hB0 + 8'(i);
      exp_q.push_back(8'hB0 + 8'(i));
      step();
    end
    sti_tvalid = 1'b0;
    chk("refill_cnt", int'(sts_cnt), 2);
    #2;
    rst = 1'b0;
    #1;
    chk("async_cnt", int'(sts_cnt), 0);
    chk("async_tvalid", int'(sto_tvalid), 0);
    chk("async_tready", int'(sti_tready), 1);
    exp_q.delete();
    #2;
    rst = 1'b1;
    step();
    chk("postrst_cnt", int'(sts_cnt), 0);

    // One beat through after reset to confirm recovery
    sti_tvalid = 1'b1;
    sti_tdata  = 8'h5A;
    sto_tready = 1'b1;
    exp_q.push_back(8'h5A);
    step();
    sti_tvalid = 1'b0;
    chk("recover_cnt", int'(sts_cnt), 1);
    step();
    chk("recover_empty_cnt", int'(sts_cnt), 0);
    chk("scoreboard_left", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wav_stream_fifo.md
# wav_stream_fifo

Synchronous stream FIFO inserted between the counter stream source and the stream drain, decoupling source valid from drain ready. Accepts beats on a ready/valid input stream, stores up to DEPTH beats, and presents them in order on a ready/valid output stream with first-word fall-through. Also reports occupancy and supports a synchronous flush.

## Interface
- DW, 8, stream data width in bits (≥1)
- DEPTH, 4, storage depth in beats; power of two, ≥2
- clk  input  1  clock; all state updates on the rising edge
- rst  input  1  asynchronous reset, active-low (rst=0 resets); release is synchronous to clk externally
- ctl_clr  input  1  synchronous flush; empties the FIFO at the next clk edge
- sti_tvalid  input  1  input stream valid
- sti_tready  output  1  input stream ready (FIFO not full)
- sti_tdata  input  DW  input stream data
- sto_tvalid  output  1  output stream valid (FIFO not empty)
- sto_tready  input  1  output stream ready
- sto_tdata  output  DW  output stream data (head entry)
- sts_cnt  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH

## Operation
- Input transfer: sti_trn = sti_tvalid & sti_tready; output transfer: sto_trn = sto_tvalid & sto_tready.
- Pointers wr_ptr, rd_ptr: AW+1 bits, AW=$clog2(DEPTH); low AW bits address memory, MSB is the wrap bit.
- Empty: wr_ptr == rd_ptr. Full: low bits equal, MSBs differ.
- sti_trn: mem[wr_ptr[AW-1:0]] <= sti_tdata, wr_ptr increments modulo 2^(AW+1).
- sto_trn: rd_ptr increments modulo 2^(AW+1).
- sti_tready = !full; sto_tvalid = !empty; sto_tdata = mem[rd_ptr[AW-1:0]] (combinational read).
- sts_cnt = wr_ptr - rd_ptr (AW+1-bit unsigned subtraction, wrap-safe), registered as a counter or derived; must equal pointer difference every cycle.
- No combinational path from sto_tready to sti_tready or from sti_tvalid to sto_tvalid.
- Simultaneous sti_trn and sto_trn: both pointers advance, sts_cnt unchanged.
- Full with sto_trn in the same cycle: sti_tready stays low (no write); one entry frees at the edge, sti_tready high next cycle.
- Empty: no bypass; sto_tvalid low even if sti_tvalid high.
- ctl_clr=1: at the next edge wr_ptr=rd_ptr=0, regardless of concurrent transfers (the concurrent write is discarded; the concurrent read counts as completed for the drain). Memory contents not cleared.
- sto_tdata is don't-care while sto_tvalid=0.

## Timing
- Reset (rst=0, asynchronous): wr_ptr=0, rd_ptr=0 → sti_tready=1, sto_tvalid=0, sts_cnt=0. sto_tdata unspecified (memory not reset).
- Reset mid-operation: all stored beats lost immediately; outputs take reset values without waiting for clk.
- Write-to-read latency: beat accepted at edge N appears on sto_tdata with sto_tvalid=1 in the cycle after edge N (1 cycle).
- Full-to-ready latency: read at edge N → sti_tready=1 after edge N.
- Throughput: one beat per cycle sustained when both sides are continuously valid/ready and occupancy is between 1 and DEPTH-1.
- sts_cnt updates on the same edge as the pointers.

## Structure
- Package wav_stream_pkg: default DW constant, and a function returning pointer width for a given depth (shared with future stream blocks).
- Optional sub-module wav_stream_fifo_mem: DEPTH×DW register array with one synchronous write port and one combinational read port; pointers, flags and count stay in wav_stream_fifo.
- Parameter check: elaboration-time error if DEPTH is not a power of two or is <2.

## Test plan
- Reset: rst=0 with sti_tvalid=1 → sti_tready=1, sto_tvalid=0, sts_cnt=0; no write.
- Fill: DEPTH=4, sto_tready=0, push 0x00..0x03 → sts_cnt 1,2,3,4; sti_tready=0 after 4th edge; 5th beat 0x04 held, not accepted.
- Drain/order: from full, sto_tready=1 → outputs 0x00,0x01,0x02,0x03 on consecutive cycles, sto_tvalid=0 after 4th edge, sts_cnt=0.
- Streaming + wrap: both sides always ready/valid, 20 beats counter data 0x00..0x13 → output identical sequence, no gaps after first beat, sts_cnt stays 1.
- Full with concurrent read: full, sti_tvalid=1, sto_tready=1 one cycle → no write that edge, sts_cnt 4→3, next cycle write accepted, sts_cnt 3 (read+write).
- Flush and async reset: 3 beats stored, ctl_clr=1 one cycle → sts_cnt=0, sto_tvalid=0 next cycle; refill 2 beats, assert rst=0 mid-cycle → sts_cnt=0 immediately.
